// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter owning a small data memory; port 1 may lock
// the memory for bursts, bounded by a timeout that raises a sticky error.
module dmem_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  input  logic          lock1,
  input  logic          err_clr,
  output logic          locked,
  output logic          lock_err
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOCK    = 2'd1,
    S_HOLDOFF = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            lock_err_q, lock_err_d;
  logic            rvalid0_q, rvalid1_q;
  logic [DW-1:0]   rdata0_q, rdata1_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            elig0, elig1;

  // Grant: port 0 is shut out while locked; ties go to the port not served last.
  always_comb begin
    elig0 = req0 & (state_q != S_LOCK) & ~rst;
    elig1 = req1 & ~rst;
    gnt0  = elig0 & (~elig1 | last_q);
    gnt1  = elig1 & (~elig0 | ~last_q);
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = lock_err_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
    if (err_clr) begin
      lock_err_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (gnt1 && lock1) begin
          state_d    = S_LOCK;
          lock_cnt_d = '0;
        end
      end
      S_LOCK: begin
        if (!lock1) begin
          state_d = S_IDLE;
        end else if (lock_cnt_q == CW'(LOCK_MAX - 1)) begin
          state_d    = S_HOLDOFF;
          lock_err_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      S_HOLDOFF: begin
        if (!lock1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Storage is intentionally not reset; grants are forced low during reset.
  always_ff @(posedge clk) begin
    if (gnt0 && we0) begin
      mem[addr0] <= wdata0;
    end else if (gnt1 && we1) begin
      mem[addr1] <= wdata1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (gnt0 && !we0) begin
        rdata0_q <= mem[addr0];
      end
      if (gnt1 && !we1) begin
        rdata1_q <= mem[addr1];
      end
    end
  end

  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign locked   = (state_q == S_LOCK);
  assign lock_err = lock_err_q;

endmodule
